// File: rtl/rs_fifo_srl_af_ctrl_pkg.sv
// Shared definitions for the rs_fifo family: sizing helper, registered flag bundle
// and the occupancy-to-flag mapping used by every FIFO controller.
package rs_fifo_srl_af_ctrl_pkg;

  typedef struct packed {
    logic full_n;
    logic empty_n;
    logic almost_empty_n;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RESET = '{full_n: 1'b1, empty_n: 1'b0, almost_empty_n: 1'b0};

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // afull_level is DEPTH-GRACE_PERIOD: full_n drops early so in-flight writes still fit.
  function automatic fifo_flags_t calc_flags(input int unsigned occ,
                                             input int unsigned afull_level,
                                             input int unsigned aempty_level);
    fifo_flags_t f;
    f.full_n         = (occ < afull_level);
    f.empty_n        = (occ != 0);
    f.almost_empty_n = (occ > aempty_level);
    return f;
  endfunction

endpackage

// File: rtl/rs_fifo_srl_af_ctrl_if.sv
// Write/read handshake bundle of the SRL FIFO; master is the stream side, slave is the FIFO.
interface rs_fifo_srl_af_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_write;
  logic                  if_write_ce;
  logic                  if_full_n;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_read;
  logic                  if_read_ce;
  logic                  if_empty_n;
  logic                  if_almost_empty_n;

  modport master (
    output if_din, if_write, if_write_ce, if_read, if_read_ce,
    input  if_full_n, if_dout, if_empty_n, if_almost_empty_n
  );

  modport slave (
    input  if_din, if_write, if_write_ce, if_read, if_read_ce,
    output if_full_n, if_dout, if_empty_n, if_almost_empty_n
  );
endinterface

// File: rtl/rs_fifo_srl_af_ctrl_shift_core.sv
// Pure shift-register storage with addressable tap; no reset so it maps onto SRL primitives.
module rs_srl_shift_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] q
);

  (* shreg_extract = "yes" *) logic [DATA_WIDTH-1:0] srl [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      srl[0] <= data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        srl[i] <= srl[i-1];
      end
    end
  end

  assign q = srl[a];

endmodule

// File: rtl/rs_fifo_srl_af_ctrl.sv
// SRL FIFO controller: push/pop qualification, occupancy counter, registered status flags
// with an early almost-full for producers with in-flight writes, and sticky overflow.
module rs_fifo_srl_af_ctrl
  import rs_fifo_srl_af_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 4,
  parameter int DEPTH              = 16,
  parameter int GRACE_PERIOD       = 2,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  rs_fifo_srl_af_ctrl_if.slave  fifo,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  overflow_err
);

  if (DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("rs_fifo_srl_af_ctrl: DEPTH=%0d outside 2..2**ADDR_WIDTH", DEPTH);
  end
  if (GRACE_PERIOD < 0 || GRACE_PERIOD > DEPTH - 1) begin : g_bad_grace
    $error("rs_fifo_srl_af_ctrl: GRACE_PERIOD=%0d outside 0..DEPTH-1", GRACE_PERIOD);
  end

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic                  wr_req;
  logic                  rd_req;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [ADDR_WIDTH:0]   occ_nxt;
  logic [ADDR_WIDTH-1:0] head_addr;
  fifo_flags_t           flags_nxt;
  fifo_flags_t           flags_q;

  assign wr_req = fifo.if_write & fifo.if_write_ce;
  assign rd_req = fifo.if_read & fifo.if_read_ce;
  assign pop    = rd_req & (occupancy != '0);
  // A full FIFO still takes a write when the same cycle pops: the shift discards the head.
  assign push   = wr_req & ((occupancy != DEPTH_C) | pop);
  assign drop   = wr_req & ~push;

  always_comb begin
    occ_nxt = occupancy;
    if (push && !pop) begin
      occ_nxt = occupancy + 1'b1;
    end else if (pop && !push) begin
      occ_nxt = occupancy - 1'b1;
    end
  end

  assign flags_nxt = calc_flags(32'(occ_nxt),
                                32'(DEPTH - GRACE_PERIOD),
                                32'(ALMOST_EMPTY_LEVEL));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy    <= '0;
      flags_q      <= FLAGS_RESET;
      overflow_err <= 1'b0;
    end else begin
      occupancy <= occ_nxt;
      flags_q   <= flags_nxt;
      if (drop) begin
        overflow_err <= 1'b1;
      end
    end
  end

  assign head_addr = ADDR_WIDTH'(occupancy - 1'b1);

  rs_srl_shift_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk  (clk),
    .ce   (push),
    .data (fifo.if_din),
    .a    (head_addr),
    .q    (fifo.if_dout)
  );

  assign fifo.if_full_n         = flags_q.full_n;
  assign fifo.if_empty_n        = flags_q.empty_n;
  assign fifo.if_almost_empty_n = flags_q.almost_empty_n;

endmodule

// File: tb/tb_rs_fifo_srl_af_ctrl.sv
// Directed bench for rs_fifo_srl_af_ctrl at DEPTH=16, GRACE_PERIOD=2, ALMOST_EMPTY_LEVEL=1.
module tb_rs_fifo_srl_af_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] occupancy;
  logic       overflow_err;
  int         tests_run;
  int         tests_failed;

  rs_fifo_srl_af_ctrl_if #(.DATA_WIDTH(32)) bus ();

  rs_fifo_srl_af_ctrl #(
    .DATA_WIDTH         (32),
    .ADDR_WIDTH         (4),
    .DEPTH              (16),
    .GRACE_PERIOD       (2),
    .ALMOST_EMPTY_LEVEL (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo         (bus),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [31:0] d);
    bus.if_write = w;
    bus.if_read  = r;
    bus.if_din   = d;
    @(posedge clk);
    #1;
    bus.if_write = 1'b0;
    bus.if_read  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_occ"},   32'(occupancy),             32'd0);
    check({tag, "_empn"},  32'(bus.if_empty_n),        32'd0);
    check({tag, "_aempn"}, 32'(bus.if_almost_empty_n), 32'd0);
    check({tag, "_fulln"}, 32'(bus.if_full_n),         32'd1);
    check({tag, "_ovf"},   32'(overflow_err),          32'd0);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    reset           = 1'b1;
    bus.if_din      = '0;
    bus.if_write    = 1'b0;
    bus.if_write_ce = 1'b1;
    bus.if_read     = 1'b0;
    bus.if_read_ce  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    #3 reset = 1'b0;
    @(posedge clk);
    #1;

    // Fill 0..15: full_n low from the 14th write onward.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 32'(i));
      check($sformatf("fill_fulln%0d", i), 32'(bus.if_full_n), 32'((i + 1) < 14));
    end
    check("fill_occ", 32'(occupancy), 32'd16);

    // Overflow: dropped write, sticky flag, head unchanged.
    cyc(1'b1, 1'b0, 32'hAA);
    check("ovf_occ",  32'(occupancy),    32'd16);
    check("ovf_flag", 32'(overflow_err), 32'd1);
    check("ovf_head", bus.if_dout,       32'd0);

    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_dout%0d", i), bus.if_dout, 32'(i));
      cyc(1'b0, 1'b1, 32'd0);
      check($sformatf("drain_empn%0d", i), 32'(bus.if_empty_n), 32'(i < 15));
    end
    check("drain_ovf_sticky", 32'(overflow_err), 32'd1);
    check("drain_occ",        32'(occupancy),    32'd0);

    // Underflow is silent.
    cyc(1'b0, 1'b1, 32'd0);
    check("uflow_occ",  32'(occupancy),     32'd0);
    check("uflow_empn", 32'(bus.if_empty_n), 32'd0);

    // Steady-state read+write at occupancy 5.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'h200 + 32'(i));
    for (int k = 0; k < 10; k++) begin
      check($sformatf("rw_dout%0d", k), bus.if_dout, 32'h200 + 32'(k));
      cyc(1'b1, 1'b1, 32'h205 + 32'(k));
      check($sformatf("rw_occ%0d", k), 32'(occupancy), 32'd5);
    end
    check("rw_dout_end", bus.if_dout, 32'h20A);

    // Reset mid-stream at occupancy 9.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h20F + 32'(i));
    check("pre_rst_occ", 32'(occupancy), 32'd9);
    #2 reset = 1'b1;
    #1;
    check_reset_state("midrst");
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 32'h55);
    check("post_rst_dout",  bus.if_dout,                32'h55);
    check("post_rst_occ",   32'(occupancy),             32'd1);
    check("post_rst_aempn", 32'(bus.if_almost_empty_n), 32'd0);
    cyc(1'b0, 1'b1, 32'd0);
    check("post_rst_drain", 32'(occupancy), 32'd0);

    // Read+write while empty: only the write lands.
    cyc(1'b1, 1'b1, 32'h100);
    check("b0_occ",  32'(occupancy), 32'd1);
    check("b0_dout", bus.if_dout,    32'h100);
    cyc(1'b0, 1'b1, 32'd0);

    // Read+write while full: both accepted, no overflow.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 32'h300 + 32'(i));
    check("b16_fulln", 32'(bus.if_full_n), 32'd0);
    cyc(1'b1, 1'b1, 32'h3FF);
    check("b16_occ",  32'(occupancy),    32'd16);
    check("b16_ovf",  32'(overflow_err), 32'd0);
    check("b16_dout", bus.if_dout,       32'h301);

    // CE gating and almost-empty threshold.
    pulse_reset();
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 32'hC0);
    check("ae_occ1", 32'(bus.if_almost_empty_n), 32'd0);
    cyc(1'b1, 1'b0, 32'hC1);
    check("ae_occ2", 32'(bus.if_almost_empty_n), 32'd1);
    bus.if_write_ce = 1'b0;
    bus.if_read_ce  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, 32'hDEAD);
      check($sformatf("ce_occ%0d", k), 32'(occupancy), 32'd2);
    end
    check("ce_dout", bus.if_dout, 32'hC0);
    bus.if_write_ce = 1'b1;
    bus.if_read_ce  = 1'b1;
    cyc(1'b0, 1'b1, 32'd0);
    check("ce_rd_occ",   32'(occupancy),             32'd1);
    check("ce_rd_aempn", 32'(bus.if_almost_empty_n), 32'd0);
    check("ce_rd_dout",  bus.if_dout,                32'hC1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
